// File: rtl/core_pkg.sv
// Shared writeback encodings, load funct3 codes and the writeback pipe tag.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam int CORE_DATA_W = 32;
    localparam int CORE_SRC_W  = 4;   // room for up to 16 read sources

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_PC   = 2'b11;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    // One in-flight writeback entry, captured in EX and carried to the output stage.
    typedef struct packed {
        logic                   valid;
        logic [1:0]             wb_sel;
        logic [2:0]             funct3;
        logic [1:0]             off;
        logic [CORE_SRC_W-1:0]  src;
        logic                   hit;
        logic [4:0]             rd;
        logic                   we;
        logic [CORE_DATA_W-1:0] alu;
        logic [CORE_DATA_W-1:0] pc4;
    } pipe_tag_t;

endpackage

// File: rtl/load_extend.sv
// Aligns a loaded word by byte offset and sign/zero-extends per load funct3.
// Latency: combinational.
// Backpressure: none.
module load_extend
    import core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_off,
    input  logic [2:0]        i_funct3,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and half; halves ignore the low offset bit.
    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_word[{i_off[1], 4'b0000} +: 16];
    end

    // Extend according to the load type; unknown codes pass the raw word.
    always_comb begin
        o_data = i_word;
        case (i_funct3)
            FUNCT3_LB:  o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            FUNCT3_LH:  o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            FUNCT3_LBU: o_data = {{(DATA_W-8){1'b0}}, w_byte};
            FUNCT3_LHU: o_data = {{(DATA_W-16){1'b0}}, w_half};
            FUNCT3_LW:  o_data = i_word;
            default:    o_data = i_word;
        endcase
    end

endmodule

// File: rtl/wb_select_pipe.sv
// Writeback select: carries EX control through a READ_LAT tag pipe, picks ALU/PC+4/aligned load data.
// Latency: result visible READ_LAT cycles after EX capture, combinational from the output stage.
// Backpressure: stall freezes every stage and holds wb_data; flush kills all entries and wins over stall.
module wb_select_pipe
    import core_pkg::*;
#(
    parameter int DATA_W   = 32,   // must equal CORE_DATA_W (pipe tag width)
    parameter int ADDR_W   = 32,
    parameter int NUM_MEM  = 3,
    parameter int READ_LAT = 1,    // 1..2
    parameter logic [NUM_MEM*4-1:0] REGION_CODES = {4'b0100, 4'b0001, 4'b1000},
    parameter logic [NUM_MEM*4-1:0] REGION_MASKS = {4'b1111, 4'b1101, 4'b1111}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic [1:0]                ex_wb_sel,
    input  logic [2:0]                ex_funct3,
    input  logic [ADDR_W-1:0]         ex_addr,
    input  logic [DATA_W-1:0]         ex_alu_result,
    input  logic [DATA_W-1:0]         ex_pc_plus4,
    input  logic [4:0]                ex_rd,
    input  logic                      ex_reg_we,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [NUM_MEM*DATA_W-1:0] mem_rdata,
    output logic                      wb_valid,
    output logic [DATA_W-1:0]         wb_data,
    output logic [4:0]                wb_rd,
    output logic                      wb_we,
    output logic                      wb_region_miss
);

    pipe_tag_t             r_stage [READ_LAT];
    pipe_tag_t             w_ex_tag;
    pipe_tag_t             w_out;
    logic [3:0]            w_nib;
    logic                  w_hit;
    logic [CORE_SRC_W-1:0] w_src;
    logic [DATA_W-1:0]     w_word;
    logic [DATA_W-1:0]     w_ext;
    logic [DATA_W-1:0]     w_live_dat;
    logic [DATA_W-1:0]     r_hold_dat;
    logic                  r_hold_vld;

    assign w_nib = ex_addr[ADDR_W-1 -: 4];

    // Region decode: scan high to low so the lowest matching index wins.
    always_comb begin
        w_hit = 1'b0;
        w_src = '0;
        for (int i = NUM_MEM - 1; i >= 0; i--) begin
            if ((w_nib & REGION_MASKS[i*4 +: 4]) == (REGION_CODES[i*4 +: 4] & REGION_MASKS[i*4 +: 4])) begin
                w_hit = 1'b1;
                w_src = CORE_SRC_W'(i);
            end
        end
    end

    // Assemble the tag captured from EX.
    always_comb begin
        w_ex_tag        = '0;
        w_ex_tag.valid  = ex_valid;
        w_ex_tag.wb_sel = ex_wb_sel;
        w_ex_tag.funct3 = ex_funct3;
        w_ex_tag.off    = ex_addr[1:0];
        w_ex_tag.src    = w_src;
        w_ex_tag.hit    = w_hit;
        w_ex_tag.rd     = ex_rd;
        w_ex_tag.we     = ex_reg_we;
        w_ex_tag.alu    = ex_alu_result;
        w_ex_tag.pc4    = ex_pc_plus4;
    end

    // Tag pipeline: flush clears every valid, stall freezes, otherwise shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < READ_LAT; k++) r_stage[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < READ_LAT; k++) r_stage[k].valid <= 1'b0;
        end else if (!stall) begin
            r_stage[0] <= w_ex_tag;
            for (int k = 1; k < READ_LAT; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign w_out = r_stage[READ_LAT-1];

    // Route the selected source's read word to the extender.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (w_out.src == CORE_SRC_W'(i)) w_word = mem_rdata[i*DATA_W +: DATA_W];
        end
    end

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .i_word   (w_word),
        .i_off    (w_out.off),
        .i_funct3 (w_out.funct3),
        .o_data   (w_ext)
    );

    // Live writeback data; invalid entries and region misses read as zero.
    always_comb begin
        w_live_dat = '0;
        if (w_out.valid) begin
            case (w_out.wb_sel)
                WB_ALU:  w_live_dat = w_out.alu;
                WB_PC:   w_live_dat = w_out.pc4;
                WB_MEM:  w_live_dat = w_out.hit ? w_ext : '0;
                default: w_live_dat = '0;
            endcase
        end
    end

    // Hold register: snapshot live data on the first stalled edge, drop it when stall ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_dat <= '0;
            r_hold_vld <= 1'b0;
        end else if (flush) begin
            r_hold_dat <= '0;
            r_hold_vld <= 1'b0;
        end else if (stall) begin
            if (!r_hold_vld) r_hold_dat <= w_live_dat;
            r_hold_vld <= 1'b1;
        end else begin
            r_hold_vld <= 1'b0;
        end
    end

    assign wb_valid       = w_out.valid;
    assign wb_data        = (stall && r_hold_vld) ? r_hold_dat : w_live_dat;
    assign wb_rd          = w_out.valid ? w_out.rd : 5'd0;
    assign wb_we          = w_out.valid & w_out.we & (w_out.rd != 5'd0);
    assign wb_region_miss = w_out.valid & (w_out.wb_sel == WB_MEM) & ~w_out.hit;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Bench for wb_select_pipe: READ_LAT=1 and READ_LAT=2 instances share stimulus.
// Latency: n/a.
// Backpressure: stall/flush driven directly and randomly.
module tb_wb_select_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_valid;
    logic [1:0]  ex_wb_sel;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_pc_plus4;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        stall;
    logic        flush;
    logic [95:0] mem_rdata;

    logic        v0, we0, miss0, v1, we1, miss1;
    logic [31:0] d0, d1;
    logic [4:0]  rd0, rd1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_select_pipe #(.READ_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_wb_sel(ex_wb_sel),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_alu_result(ex_alu_result),
        .ex_pc_plus4(ex_pc_plus4), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .stall(stall), .flush(flush), .mem_rdata(mem_rdata),
        .wb_valid(v0), .wb_data(d0), .wb_rd(rd0), .wb_we(we0), .wb_region_miss(miss0)
    );

    wb_select_pipe #(.READ_LAT(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_wb_sel(ex_wb_sel),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_alu_result(ex_alu_result),
        .ex_pc_plus4(ex_pc_plus4), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .stall(stall), .flush(flush), .mem_rdata(mem_rdata),
        .wb_valid(v1), .wb_data(d1), .wb_rd(rd1), .wb_we(we1), .wb_region_miss(miss1)
    );

    typedef struct packed {
        bit        valid;
        bit [1:0]  sel;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] alu;
        bit [31:0] pc4;
        bit [4:0]  rd;
        bit        we;
    } instr_t;

    // mp[d][age]: instructions captured by instance d, age 0 newest; instance d shows age d.
    instr_t    mp [2][2];
    bit        hold_act [2];
    bit [31:0] hold_val [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    // Source index for an address nibble: mmio 0x8, dmem 0x1/0x3, bios 0x4.
    function automatic int region_of(bit [3:0] nib);
        if (nib == 4'h8) return 0;
        if (nib == 4'h1 || nib == 4'h3) return 1;
        if (nib == 4'h4) return 2;
        return -1;
    endfunction

    function automatic bit [31:0] ext(bit [31:0] w, bit [1:0] off, bit [2:0] f3);
        bit [31:0] b;
        bit [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit [31:0] live(int d);
        instr_t e;
        int     r;
        e = mp[d][d];
        if (!e.valid) return 32'h0;
        case (e.sel)
            2'd1: return e.alu;
            2'd3: return e.pc4;
            2'd2: begin
                r = region_of(e.addr[31:28]);
                if (r < 0) return 32'h0;
                return ext(mem_rdata[r*32 +: 32], e.addr[1:0], e.f3);
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mp[d][0] = '0;
            mp[d][1] = '0;
            hold_act[d] = 1'b0;
            hold_val[d] = 32'h0;
        end
    endtask

    task automatic model_edge();
        instr_t nw;
        nw.valid = ex_valid;   nw.sel = ex_wb_sel;   nw.f3 = ex_funct3;
        nw.addr  = ex_addr;    nw.alu = ex_alu_result; nw.pc4 = ex_pc_plus4;
        nw.rd    = ex_rd;      nw.we  = ex_reg_we;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (flush) begin
                    mp[d][0].valid = 1'b0;
                    mp[d][1].valid = 1'b0;
                    hold_act[d] = 1'b0;
                    hold_val[d] = 32'h0;
                end else if (stall) begin
                    if (!hold_act[d]) hold_val[d] = live(d);
                    hold_act[d] = 1'b1;
                end else begin
                    mp[d][1] = mp[d][0];
                    mp[d][0] = nw;
                    hold_act[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic model_check();
        for (int d = 0; d < 2; d++) begin
            instr_t    e;
            bit [31:0] ed;
            bit        emiss;
            e = mp[d][d];
            ed = (stall && hold_act[d]) ? hold_val[d] : live(d);
            emiss = e.valid && (e.sel == 2'd2) && (region_of(e.addr[31:28]) < 0);
            check($sformatf("L%0d_valid", d + 1), 32'(d == 0 ? v0 : v1), 32'(e.valid));
            check($sformatf("L%0d_data", d + 1), d == 0 ? d0 : d1, ed);
            check($sformatf("L%0d_rd", d + 1), 32'(d == 0 ? rd0 : rd1), 32'(e.valid ? e.rd : 5'd0));
            check($sformatf("L%0d_we", d + 1), 32'(d == 0 ? we0 : we1), 32'(e.valid && e.we && e.rd != 0));
            check($sformatf("L%0d_miss", d + 1), 32'(d == 0 ? miss0 : miss1), 32'(emiss));
        end
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_wb_sel = 2'd0; ex_funct3 = 3'd0; ex_addr = 32'h0;
        ex_alu_result = 32'h0; ex_pc_plus4 = 32'h0; ex_rd = 5'd0; ex_reg_we = 1'b0;
        stall = 1'b0; flush = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom};
    endtask

    task automatic set_ex(input bit [1:0] sel, input bit [2:0] f3, input bit [31:0] addr,
                          input bit [31:0] alu, input bit [31:0] pc4, input bit [4:0] rd, input bit we);
        ex_valid = 1'b1; ex_wb_sel = sel; ex_funct3 = f3; ex_addr = addr;
        ex_alu_result = alu; ex_pc_plus4 = pc4; ex_rd = rd; ex_reg_we = we;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_v1"}, 32'(v0), 32'h0);
        check({tag, "_d1"}, d0, 32'h0);
        check({tag, "_we1"}, 32'(we0), 32'h0);
        check({tag, "_rd1"}, 32'(rd0), 32'h0);
        check({tag, "_miss1"}, 32'(miss0), 32'h0);
        check({tag, "_v2"}, 32'(v1), 32'h0);
        check({tag, "_d2"}, d1, 32'h0);
        check({tag, "_we2"}, 32'(we1), 32'h0);
    endtask

    initial begin
        bit [3:0] nib;
        idle();
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // LB from dmem, byte 3 sign-extended
        idle(); set_ex(2'd2, 3'd0, 32'h1000_0003, 0, 0, 5'd5, 1'b1); settle(); tick();
        idle(); mem_rdata[63:32] = 32'h80FF_1234; settle();
        check("lb_data", d0, 32'hFFFF_FF80);
        check("lb_we", 32'(we0), 32'h1);
        tick();

        // LHU then LH at offset 3 from bios
        idle(); set_ex(2'd2, 3'd5, 32'h4000_0002, 0, 0, 5'd6, 1'b1); settle(); tick();
        idle(); set_ex(2'd2, 3'd1, 32'h4000_0003, 0, 0, 5'd6, 1'b1);
        mem_rdata[95:64] = 32'hBEEF_0001; settle();
        check("lhu_data", d0, 32'h0000_BEEF);
        tick();
        idle(); mem_rdata[95:64] = 32'hBEEF_0001; settle();
        check("lh_data", d0, 32'hFFFF_BEEF);
        tick();

        // Region miss, then ALU op to x0
        idle(); set_ex(2'd2, 3'd2, 32'h2000_0000, 0, 0, 5'd8, 1'b1); settle(); tick();
        idle(); set_ex(2'd1, 3'd0, 32'h0, 32'h55, 0, 5'd0, 1'b1); settle();
        check("miss_data", d0, 32'h0);
        check("miss_flag", 32'(miss0), 32'h1);
        tick();
        idle(); settle();
        check("x0_we", 32'(we0), 32'h0);
        check("x0_valid", 32'(v0), 32'h1);
        tick();

        // Stall holds the loaded word against changing read data
        idle(); set_ex(2'd2, 3'd2, 32'h1000_0000, 0, 0, 5'd7, 1'b1); settle(); tick();
        idle(); stall = 1'b1; mem_rdata[63:32] = 32'h1234_5678; settle();
        check("stall_first", d0, 32'h1234_5678);
        tick();
        for (int i = 0; i < 2; i++) begin
            idle(); stall = 1'b1; mem_rdata[63:32] = 32'hDEAD_BEEF; settle();
            check("stall_hold", d0, 32'h1234_5678);
            tick();
        end
        idle(); mem_rdata[63:32] = 32'hDEAD_BEEF; settle();
        check("stall_release", d0, 32'hDEAD_BEEF);
        tick();

        // Flush together with stall kills in-flight and newly captured entries
        idle(); set_ex(2'd2, 3'd2, 32'h1000_0000, 0, 0, 5'd9, 1'b1); settle(); tick();
        idle(); set_ex(2'd1, 3'd0, 0, 32'h99, 0, 5'd10, 1'b1); flush = 1'b1; stall = 1'b1; settle();
        check("flush_pre", 32'(v0), 32'h1);
        tick();
        idle(); settle();
        check("flush_v1", 32'(v0), 32'h0);
        check("flush_v2", 32'(v1), 32'h0);
        tick();

        // Asynchronous reset in the middle of traffic
        idle(); set_ex(2'd1, 3'd0, 0, 32'h77, 0, 5'd3, 1'b1); settle(); tick();
        idle(); set_ex(2'd1, 3'd0, 0, 32'h88, 0, 5'd4, 1'b1); settle();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        model_reset();
        tick();
        rst_n = 1'b1;

        // Back-to-back ALU, MEM, PC+4 through the two-deep pipe
        idle(); settle(); tick();
        idle(); set_ex(2'd1, 3'd0, 0, 32'hA1, 0, 5'd1, 1'b1); settle(); tick();
        idle(); set_ex(2'd2, 3'd2, 32'h4000_0000, 0, 0, 5'd2, 1'b1); settle();
        check("l2_empty", 32'(v1), 32'h0);
        tick();
        idle(); set_ex(2'd3, 3'd0, 0, 0, 32'h104, 5'd3, 1'b1); settle();
        check("l2_alu", d1, 32'hA1);
        tick();
        idle(); mem_rdata[95:64] = 32'hCAFE_F00D; settle();
        check("l2_mem", d1, 32'hCAFE_F00D);
        tick();
        idle(); settle();
        check("l2_pc", d1, 32'h104);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            idle();
            case ($urandom_range(0, 7))
                0: nib = 4'h8;
                1: nib = 4'h1;
                2: nib = 4'h3;
                3: nib = 4'h4;
                default: nib = 4'($urandom_range(0, 15));
            endcase
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_wb_sel     = 2'($urandom_range(0, 3));
            ex_funct3     = 3'($urandom_range(0, 7));
            ex_addr       = {nib, 28'($urandom)};
            ex_alu_result = $urandom;
            ex_pc_plus4   = $urandom;
            ex_rd         = 5'($urandom_range(0, 31));
            ex_reg_we     = 1'($urandom_range(0, 1));
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 15) == 0);
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
